imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles little-endian words and writes them out.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  len,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int IW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    FINISH
  } state_t;

  state_t      state, state_n;
  logic [IW-1:0] idx;
  logic [1:0]  bcnt;
  logic [6:0]  len_q;
  logic        err_q;
  logic        fire, len_ok, last_word, ck_fail;

  assign fire      = in_valid && in_ready;
  assign len_ok    = (len != 7'd0) && (32'(len) <= DEPTH);
  assign last_word = (32'(idx) + 32'd1) == 32'(len_q);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  assign ck_fail = (state == CHECK) && fire && (in_data != sum);
`else
  assign ck_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start && len_ok) state_n = RECV;
      RECV:   if (fire && bcnt == 2'd3) state_n = WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      WRITE:  state_n = last_word ? CHECK : RECV;
      CHECK:  if (fire) state_n = (in_data == sum) ? FINISH : IDLE;
`else
      WRITE:  state_n = last_word ? FINISH : RECV;
`endif
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      bcnt  <= '0;
      len_q <= '0;
      wdata <= '0;
      err_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      err_q <= ((state == IDLE) && start && !len_ok) || ck_fail;
      case (state)
        IDLE: if (start && len_ok) begin
          len_q <= len;
          idx   <= '0;
          bcnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum   <= '0;
`endif
        end
        RECV: if (fire) begin
          wdata[{bcnt, 3'b000} +: 8] <= in_data;
          bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum  <= sum + in_data;
`endif
        end
        WRITE: idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Address is gated to WRITE so the post-increment index (== len) never leaks out.
  assign waddr    = (state == WRITE) ? (32'(idx) << 2) : 32'd0;
  assign we       = (state == WRITE);
  assign done     = (state == FINISH);
  assign busy     = (state != IDLE);
  assign err      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = (state == RECV) || (state == CHECK);
`else
  assign in_ready = (state == RECV);
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte/word-level reference model.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, we, busy, done, err;
  logic [31:0] waddr, wdata;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  imem_loader #(.DEPTH(64)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] pay[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({in_ready, we, busy, done, err}), 32'd0);
    chk({tag, "_waddr"}, waddr, 32'd0);
    chk({tag, "_wdata"}, wdata, 32'd0);
  endtask

  task automatic do_reset(input int cyc);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bad_len(input logic [6:0] l);
    @(negedge clk);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0;
    chk("badlen_err", 32'(err), 32'd1);
    chk("badlen_ctl", 32'({in_ready, we, busy, done}), 32'd0);
    @(negedge clk);
    chk("badlen_err_off", 32'({err, in_ready, we, busy}), 32'd0);
  endtask

  // Model: expected words are the payload bytes grouped little-endian; a write appears the
  // cycle after each 4th payload byte is taken; done/err follow the last write or checksum byte.
  task automatic do_load(input int n, input int vprob, input bit spam, input int rst_at,
                         input bit ck_bad);
    logic [7:0]  b[$];
    logic [31:0] words[$];
    logic [7:0]  s;
    int k, w, total;
    bit p_we, p_done, p_err, rdy, fire, nwe, ndone, nerr;
    if (pay.size() == 0)
      for (int i = 0; i < 4 * n; i++) pay.push_back(8'($urandom));
    b = pay;
    pay.delete();
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      words.push_back({b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]});
      s = s + b[4*i] + b[4*i+1] + b[4*i+2] + b[4*i+3];
    end
    if (CK) b.push_back(ck_bad ? s + 8'd1 : s);
    total = b.size();

    @(negedge clk);
    start = 1'b1; len = 7'(n); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0; w = 0; p_we = 0; p_done = 0; p_err = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (k == rst_at && !p_we) begin
        do_reset(2);
        chk_zero("midrst");
        return;
      end
      chk("we", 32'(we), 32'(p_we));
      if (p_we) begin
        chk("waddr", waddr, 32'(w * 4));
        chk("wdata", wdata, words[w]);
        w++;
      end
      chk("done", 32'(done), 32'(p_done));
      chk("err", 32'(err), 32'(p_err));
      chk("busy", 32'(busy), 32'(!p_err));
      if (p_done || p_err) begin
        start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_idle", 32'({busy, done, err, in_ready, we}), 32'd0);
        return;
      end
      rdy = !p_we && (k < total);
      chk("in_ready", 32'(in_ready), 32'(rdy));
      in_valid = ($urandom_range(99) < vprob);
      if (vprob < 0) in_valid = (cyc % 2) == 0;
      in_data = (in_valid && k < total) ? b[k] : 8'($urandom);
      if (spam) begin
        start = 1'($urandom_range(1));
        len = 7'($urandom_range(1, 64));
      end
      fire = in_valid && rdy;
      nwe = 0; ndone = 0; nerr = 0;
      if (p_we && w == n && !CK) ndone = 1;
      if (fire) begin
        if (k < 4 * n && (k % 4) == 3) nwe = 1;
        if (k == 4 * n) begin
          if (b[k] == s) ndone = 1;
          else nerr = 1;
        end
        k++;
      end
      p_we = nwe; p_done = ndone; p_err = nerr;
      @(negedge clk);
    end
    chk("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    do_reset(2);
    chk_zero("reset");
    @(negedge clk);
    chk_zero("reset_hold");

    pay = '{8'h13, 8'h01, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};
    do_load(2, 100, 1'b0, -1, 1'b0);

    bad_len(7'd0);
    bad_len(7'd65);
    bad_len(7'd127);

    do_load(1, -1, 1'b1, -1, 1'b0);

    do_load(3, 100, 1'b0, 6, 1'b0);
    pay = '{8'h6F, 8'h00, 8'h00, 8'h02};
    do_load(1, 100, 1'b0, -1, 1'b0);

    if (CK) begin
      pay = '{8'h13, 8'h01, 8'h00, 8'h00};
      do_load(1, 100, 1'b0, -1, 1'b0);
      pay = '{8'h13, 8'h01, 8'h00, 8'h00};
      do_load(1, 100, 1'b0, -1, 1'b1);
    end

    do_load(64, 90, 1'b1, -1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      int n;
      n = $urandom_range(1, 8);
      do_load(n, $urandom_range(30, 100), 1'($urandom_range(1)),
              ($urandom_range(7) == 0) ? $urandom_range(0, 4 * n - 1) : -1,
              1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
